// File: rtl/ca3_hash_checker_if.sv
// Byte stream and status bundle for the CA3 hash checker.
//   master: frame source (start, msg_len, in_valid, in_data), observes status
//   slave : checker (in_ready, busy, done, match, timeout), observes requests
interface ca3_hash_checker_if;

    logic       start;
    logic [3:0] msg_len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       match;
    logic       timeout;

    modport master (
        output start, msg_len, in_valid, in_data,
        input  in_ready, busy, done, match, timeout
    );

    modport slave (
        input  start, msg_len, in_valid, in_data,
        output in_ready, busy, done, match, timeout
    );

endinterface

// File: rtl/ca3_hash_checker.sv
// CA3 hash checker: recomputes the 8-bit rotate-left/XOR hash over a
// received message and compares it with the trailing expected-hash byte.
//
// Ports:
//   clk   - single clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - ca3_hash_checker_if.slave: start/msg_len request, valid/ready
//           byte stream (in_valid, in_data, in_ready) and status
//           (busy, done pulse, held match/timeout)
//
// Parameters:
//   INIT    - hash seed loaded on an accepted start
//   TIMEOUT - idle-cycle limit (1..15), only with the timeout feature
//
// Build option: define CA3_HASH_CHK_TIMEOUT_EN to abort a frame after
// TIMEOUT consecutive idle cycles; otherwise timeout is tied to 0.
module ca3_hash_checker #(
    parameter logic [7:0] INIT    = 8'hA5,
    parameter logic [3:0] TIMEOUT = 4'd15
) (
    input logic               clk,
    input logic               rst_n,
    ca3_hash_checker_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSG  = 2'd1,
        ST_HASH = 2'd2
    } state_e;

    state_e     state_q;
    logic [7:0] hash_q;
    logic [3:0] cnt_q;
    logic       in_ready_q;
    logic       busy_q;
    logic       done_q;
    logic       match_q;

    logic       xfer_c;
    logic [7:0] hash_d;

    // A byte moves only while the checker is in MSG or HASH.
    assign xfer_c = bus.in_valid & in_ready_q;
    assign hash_d = {hash_q[6:0], hash_q[7]} ^ bus.in_data;

`ifdef CA3_HASH_CHK_TIMEOUT_EN
    logic [3:0] idle_q;
    logic       timeout_q;
    logic       idle_hit_c;

    // Fires on the idle cycle that brings the counter up to TIMEOUT;
    // requires in_valid low, so a transfer always takes priority.
    assign idle_hit_c = busy_q & ~bus.in_valid & (idle_q == (TIMEOUT - 4'd1));
    assign bus.timeout = timeout_q;
`else
    wire unused_timeout_param = |TIMEOUT;
    assign bus.timeout = 1'b0;
`endif

    // Frame FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hash_q     <= INIT;
            cnt_q      <= 4'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
`ifdef CA3_HASH_CHK_TIMEOUT_EN
            idle_q     <= 4'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        hash_q     <= INIT;
                        cnt_q      <= bus.msg_len;
                        match_q    <= 1'b0;
`ifdef CA3_HASH_CHK_TIMEOUT_EN
                        timeout_q  <= 1'b0;
`endif
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= (bus.msg_len != 4'd0) ? ST_MSG : ST_HASH;
                    end
                end

                ST_MSG: begin
                    if (xfer_c) begin
                        hash_q <= hash_d;
                        cnt_q  <= cnt_q - 4'd1;
                        // Leaving at cnt==1 keeps the down-counter from wrapping.
                        if (cnt_q == 4'd1) begin
                            state_q <= ST_HASH;
                        end
                    end
                end

                ST_HASH: begin
                    if (xfer_c) begin
                        match_q    <= (bus.in_data == hash_q);
                        done_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end

                default: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase

`ifdef CA3_HASH_CHK_TIMEOUT_EN
            // Idle counter: cleared outside a frame and on every transfer.
            if (xfer_c || !busy_q) begin
                idle_q <= 4'd0;
            end else begin
                idle_q <= idle_q + 4'd1;
            end

            if (idle_hit_c) begin
                done_q     <= 1'b1;
                match_q    <= 1'b0;
                timeout_q  <= 1'b1;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                state_q    <= ST_IDLE;
            end
`endif
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.match    = match_q;

endmodule

// File: tb/tb_ca3_hash_checker.sv
// Directed self-checking bench for ca3_hash_checker with hand-computed hashes.
module tb_ca3_hash_checker;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   done_cnt;

    ca3_hash_checker_if bus ();

    ca3_hash_checker #(
        .INIT    (8'hA5),
        .TIMEOUT (4'd15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Done pulses seen on clock edges (one per completed frame).
    always @(posedge clk) begin
        if (bus.done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame: start, msg bytes (optional 3-cycle stall before byte
    // stall_at), then the hash byte. Checks done timing and the final match.
    task automatic run_frame(input string tag, input int len, input logic [7:0] msg [16],
                             input logic [7:0] hbyte, input int stall_at, input logic exp_match);
        int lat;
        int d0;
        d0  = done_cnt;
        lat = 0;
        bus.start    = 1'b1;
        bus.msg_len  = 4'(len);
        bus.in_valid = 1'b0;
        tick(); lat++;
        bus.start = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_match_clr"}, 32'(bus.match), 32'd0);
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) begin
                bus.in_valid = 1'b0;
                repeat (3) begin tick(); lat++; end
                check({tag, "_stall_busy"}, 32'(bus.busy), 32'd1);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = msg[i];
            tick(); lat++;
        end
        check({tag, "_no_early_done"}, 32'(bus.done), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = hbyte;
        tick(); lat++;
        bus.in_valid = 1'b0;
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_match"}, 32'(bus.match), 32'(exp_match));
        check({tag, "_latency"}, 32'(lat), 32'(len + 2 + ((stall_at < len) ? 3 : 0)));
        tick();
        check({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
        check({tag, "_match_held"}, 32'(bus.match), 32'(exp_match));
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    endtask

    logic [7:0] m [16];

    initial begin
        checks       = 0;
        failures     = 0;
        done_cnt     = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.msg_len  = 4'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int i = 0; i < 16; i++) m[i] = 8'h00;

        // Reset
        tick(); tick();
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_match", 32'(bus.match), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        tick(); tick();
        check("idle_valid_ready", 32'(bus.in_ready), 32'd0);
        check("idle_valid_busy", 32'(bus.busy), 32'd0);
        check("idle_valid_done", 32'(done_cnt), 32'd0);
        bus.in_valid = 1'b0;

        // A5 -> 4B^01=4A -> 94^02=96
        m[0] = 8'h01; m[1] = 8'h02;
        run_frame("f_ok", 2, m, 8'h96, 99, 1'b1);
        run_frame("f_bad", 2, m, 8'h97, 99, 1'b0);
        run_frame("f_stall", 2, m, 8'h96, 1, 1'b1);

        // Empty message: hash equals seed; start while busy is ignored.
        bus.start   = 1'b1;
        bus.msg_len = 4'd0;
        tick();
        bus.msg_len = 4'd5;
        tick();
        bus.start = 1'b0;
        check("z_busy", 32'(bus.busy), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        tick();
        bus.in_valid = 1'b0;
        check("z_done", 32'(bus.done), 32'd1);
        check("z_match", 32'(bus.match), 32'd1);
        tick();
        check("z_idle", 32'(bus.busy), 32'd0);
        check("z_done_cnt", 32'(done_cnt), 32'd4);

        // Reset after one of three message bytes.
        bus.start   = 1'b1;
        bus.msg_len = 4'd3;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h10;
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_busy", 32'(bus.busy), 32'd0);
        check("mr_ready", 32'(bus.in_ready), 32'd0);
        check("mr_match", 32'(bus.match), 32'd0);
        tick();
        check("mr_no_done", 32'(done_cnt), 32'd4);
        // A5 -> 4B^10=5B -> B6^20=96 -> 2D^30=1D
        m[0] = 8'h10; m[1] = 8'h20; m[2] = 8'h30;
        run_frame("f_post", 3, m, 8'h1D, 99, 1'b1);

        // Idle in MSG for 15 cycles.
        bus.start   = 1'b1;
        bus.msg_len = 4'd2;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        repeat (14) tick();
        check("to_pre_done", 32'(bus.done), 32'd0);
        check("to_pre_busy", 32'(bus.busy), 32'd1);
        tick();
`ifdef CA3_HASH_CHK_TIMEOUT_EN
        check("to_done", 32'(bus.done), 32'd1);
        check("to_timeout", 32'(bus.timeout), 32'd1);
        check("to_match", 32'(bus.match), 32'd0);
        check("to_busy", 32'(bus.busy), 32'd0);
        tick();
        check("to_held", 32'(bus.timeout), 32'd1);
        m[0] = 8'h01; m[1] = 8'h02;
        run_frame("f_after_to", 2, m, 8'h96, 99, 1'b1);
        check("to_clr", 32'(bus.timeout), 32'd0);
`else
        check("nto_busy", 32'(bus.busy), 32'd1);
        check("nto_timeout", 32'(bus.timeout), 32'd0);
        check("nto_done", 32'(bus.done), 32'd0);
        // Finish the frame that was left waiting: 01,02 -> 96.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        tick();
        bus.in_data  = 8'h02;
        tick();
        bus.in_data  = 8'h96;
        tick();
        bus.in_valid = 1'b0;
        check("nto_late_done", 32'(bus.done), 32'd1);
        check("nto_late_match", 32'(bus.match), 32'd1);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ca3_hash_checker.md
# ca3_hash_checker

Receive-side counterpart of the CA3 hash generator. It accepts a byte message followed by one expected hash byte over a valid/ready stream. It recomputes the 8-bit rotate-XOR hash over the message and reports a one-cycle `done` pulse with a held `match` flag. It sits after the transport path and in front of the consumer that qualifies received frames.

## Interface
Parameters:
- `INIT`, 8'hA5: hash seed loaded on `start`.
- `TIMEOUT`, 15: idle-cycle limit (4-bit, 1..15). Used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- `msg_len`  in  4  message byte count, 0..15, sampled on accepted `start`.
- `in_valid`  in  1  source has a byte on `in_data`.
- `in_data`  in  8  message byte or expected hash byte.
- `in_ready`  out  1  checker accepts a byte this cycle.
- `busy`  out  1  high in MSG and HASH.
- `done`  out  1  one-cycle pulse when a frame ends.
- `match`  out  1  1 when the received hash equals the computed hash; held until the next accepted `start`.
- `timeout`  out  1  frame ended by idle timeout; held like `match`. Tied to 0 when the feature is out.

## Operation
- States: IDLE, MSG, HASH.
- Handshake: a byte transfers on a rising edge where `in_valid & in_ready` is 1. `in_ready` is a pure function of state: 1 in MSG and HASH, 0 in IDLE.
- IDLE + `start`:
  - H <= `INIT`, cnt <= `msg_len`, `match` <= 0, `timeout` <= 0.
  - Next state is MSG if `msg_len` != 0, else HASH.
- MSG, on transfer:
  - H <= {H[6:0],H[7]} ^ `in_data`; cnt <= cnt-1.
  - When cnt==1 at the transfer, go to HASH.
- HASH, on transfer:
  - `match` <= (`in_data` == H), `done` <= 1.
  - Go to IDLE.
- `start` in MSG or HASH is ignored; no restart and no state change.
- `in_valid` with `in_ready`=0 is ignored; no byte is consumed.
- Arithmetic: H is 8-bit with no carry; rotate is left by 1. cnt is a 4-bit down-counter and never wraps, because the transition fires at cnt==1.
- Reset, including mid-frame: state IDLE, H=`INIT`, cnt=0, `in_ready`=0, `busy`=0, `done`=0, `match`=0, `timeout`=0. A partial frame is discarded and no `done` is produced.

## Timing
- `done` is registered. It is high for exactly the cycle after the hash-byte transfer edge, and IDLE is entered on that same edge.
- A new `start` is accepted in the same cycle that `done` is high.
- Throughput is one byte per cycle with `in_valid` held high. Frame latency from accepted `start` to `done` is `msg_len`+2 cycles.
- `match` and `timeout` change only on an accepted `start` or on the end of a frame.

## Configuration
- Macro `CA3_HASH_CHK_TIMEOUT_EN`.
- Defined:
  - A 4-bit idle counter clears on every transfer and on state entry. It increments each MSG/HASH cycle with `in_valid`=0.
  - On reaching `TIMEOUT`: `done` <= 1, `match` <= 0, `timeout` <= 1, go to IDLE.
  - If a transfer and the timeout occur in the same cycle, the transfer wins.
- Undefined: no counter is built, `timeout` is constant 0, and the checker waits indefinitely.

## Test plan
- Reset with `rst_n`=0 for 2 cycles -> all outputs 0 and `in_ready`=0; `in_valid`=1 with no `start` -> no transfer.
- `start`, `msg_len`=2, bytes 0x01,0x02 then hash 0x96 -> H steps 0x4A, 0x96; `done`=1 one cycle, `match`=1, latency 4.
- Same frame with hash 0x97 -> `done`=1, `match`=0; then `in_valid` stalls mid-message for 3 cycles -> result unchanged after the stall.
- `msg_len`=0, hash 0xA5 -> `match`=1 after 2 cycles; `start` pulsed while `busy` -> ignored, frame count unaffected.
- `rst_n` low after 1 of 3 message bytes -> IDLE, no `done`; new frame afterwards checks correctly.
- With `CA3_HASH_CHK_TIMEOUT_EN` and `TIMEOUT`=15: `in_valid`=0 for 15 cycles in MSG -> `done`=1, `timeout`=1, `match`=0. Without the macro, the same stimulus -> `busy` stays 1 and `timeout`=0.
